// File: rtl/clk_tick_gen_if.sv
// Bus between the tick generator and its consumers: per-channel enables,
// divisor load port, tick pulses, digit-scan outputs and divisor readback.
interface clk_tick_gen_if #(
  parameter int NCH  = 3,
  parameter int CW   = 24,
  parameter int NDIG = 4
);
  localparam int DIW = $clog2(NDIG);

  logic [NCH-1:0]    en;
  logic              ld;
  logic [NCH*CW-1:0] div_in;
  logic [NCH-1:0]    tick;
  logic [NDIG-1:0]   an;
  logic [DIW-1:0]    dig_idx;
  logic [NCH*CW-1:0] div_q;

  // The controlling side drives enables and divisor loads.
  modport master (
    output en, ld, div_in,
    input  tick, an, dig_idx, div_q
  );

  // The tick generator itself.
  modport slave (
    input  en, ld, div_in,
    output tick, an, dig_idx, div_q
  );
endinterface

// File: rtl/clk_tick_gen.sv
// Multi-channel clock-enable tick generator with runtime divisors, optional
// channel-to-channel cascading and a rotating active-low digit scanner
// stepped by channel 0. Everything runs on the single pixel clock.
module clk_tick_gen #(
  parameter int                NCH     = 3,
  parameter int                CW      = 24,
  parameter logic [NCH*CW-1:0] DEF_DIV = {24'd65536, 24'd6250000, 24'd65536},
  parameter logic [NCH-1:0]    CASC    = 3'b000,
  parameter int                NDIG    = 4
) (
  input logic          clk,
  input logic          greset,
  clk_tick_gen_if.slave bus
);

  localparam int DIW = $clog2(NDIG);
  localparam logic [DIW-1:0] LAST_DIG = DIW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_RESET = {{(NDIG-1){1'b1}}, 1'b0};

  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] step;
  logic [NCH-1:0] tick_pre;
  logic [CW-1:0]  cur_div;
  logic           prev_wrap;

  // Decide per channel whether it advances this cycle and whether it wraps;
  // a cascaded channel sees its parent's wrap in the same cycle, so a chain
  // adds no latency. A zero divisor stalls the channel entirely.
  always_comb begin
    step      = '0;
    tick_pre  = '0;
    cur_div   = '0;
    prev_wrap = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cur_div = bus.div_q[i*CW +: CW];
      if (i == 0 || !CASC[i]) begin
        step[i] = bus.en[i] && (cur_div != '0);
      end else begin
        step[i] = bus.en[i] && prev_wrap && (cur_div != '0);
      end
      tick_pre[i] = step[i] && (cnt[i] == cur_div - CW'(1));
      prev_wrap   = tick_pre[i];
    end
  end

  // Counters, divisor register and tick pulses; reset beats load beats counting,
  // and a load swallows any wrap that was due on the same edge.
  always_ff @(posedge clk) begin
    if (greset) begin
      bus.div_q <= DEF_DIV;
      bus.tick  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else if (bus.ld) begin
      bus.div_q <= bus.div_in;
      bus.tick  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      bus.tick <= tick_pre;
      for (int i = 0; i < NCH; i++) begin
        if (tick_pre[i]) begin
          cnt[i] <= '0;
        end else if (step[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Digit scanner steps whenever channel 0 emits a tick; the single zero in
  // the anode vector always sits at the current digit index.
  always_ff @(posedge clk) begin
    if (greset) begin
      bus.an      <= AN_RESET;
      bus.dig_idx <= '0;
    end else if (!bus.ld && tick_pre[0]) begin
      bus.an <= {bus.an[NDIG-2:0], bus.an[NDIG-1]};
      if (bus.dig_idx == LAST_DIG) begin
        bus.dig_idx <= '0;
      end else begin
        bus.dig_idx <= bus.dig_idx + DIW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen: each step drives one cycle of inputs,
// queues the expected post-edge outputs, and checks them just after the edge.
module tb_clk_tick_gen;

  localparam int NCH  = 3;
  localparam int CW   = 24;
  localparam int NDIG = 4;
  localparam logic [NCH*CW-1:0] DEF = {24'd65536, 24'd6250000, 24'd65536};

  typedef struct {
    string             tag;
    logic [NCH-1:0]    tick;
    logic [NDIG-1:0]   an;
    logic [1:0]        idx;
    logic [NCH*CW-1:0] div;
  } exp_t;

  logic clk = 1'b0;
  logic greset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  logic [1:0]        exp_idx = '0;
  logic [NCH*CW-1:0] exp_div = DEF;

  clk_tick_gen_if #(.NCH(NCH), .CW(CW), .NDIG(NDIG)) bus ();

  clk_tick_gen #(
    .NCH(NCH), .CW(CW), .DEF_DIV(DEF), .CASC(3'b010), .NDIG(NDIG)
  ) dut (
    .clk(clk),
    .greset(greset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*CW-1:0] packDiv(input int d2, input int d1, input int d0);
    return {CW'(d2), CW'(d1), CW'(d0)};
  endfunction

  task automatic checkOutput();
    exp_t x;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      n_cmp++;
      assert (bus.tick === x.tick) else begin
        n_fail++;
        $error("[TB] FAIL %s.tick: observed %b expected %b", x.tag, bus.tick, x.tick);
      end
      n_cmp++;
      assert (bus.an === x.an) else begin
        n_fail++;
        $error("[TB] FAIL %s.an: observed %b expected %b", x.tag, bus.an, x.an);
      end
      n_cmp++;
      assert (bus.dig_idx === x.idx) else begin
        n_fail++;
        $error("[TB] FAIL %s.dig_idx: observed %0d expected %0d", x.tag, bus.dig_idx, x.idx);
      end
      n_cmp++;
      assert (bus.div_q === x.div) else begin
        n_fail++;
        $error("[TB] FAIL %s.div_q: observed %h expected %h", x.tag, bus.div_q, x.div);
      end
    end
  endtask

  // One clock cycle: drive inputs, record what the outputs must be after the
  // edge (scanner follows channel 0 ticks), then sample and compare.
  task automatic applyStimulus(input string tag, input logic rst, input logic [NCH-1:0] e,
                               input logic l, input logic [NCH*CW-1:0] d,
                               input logic [NCH-1:0] exp_tick);
    exp_t x;
    greset     = rst;
    bus.en     = e;
    bus.ld     = l;
    bus.div_in = d;
    if (rst) begin
      exp_div = DEF;
      exp_idx = '0;
    end else if (l) begin
      exp_div = d;
    end else if (exp_tick[0]) begin
      exp_idx = exp_idx + 2'd1;
    end
    x.tag  = tag;
    x.tick = exp_tick;
    x.idx  = exp_idx;
    x.an   = ~(4'b0001 << exp_idx);
    x.div  = exp_div;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    bus.en     = '0;
    bus.ld     = 1'b0;
    bus.div_in = '0;
    @(negedge clk);

    $display("[TB] reset defaults");
    for (int k = 0; k < 3; k++)
      applyStimulus("reset", 1'b1, 3'b111, 1'b1, packDiv(5, 5, 5), 3'b000);

    $display("[TB] basic period D0=5");
    applyStimulus("basic_ld", 1'b0, 3'b000, 1'b1, packDiv(0, 0, 5), 3'b000);
    for (int k = 1; k <= 20; k++)
      applyStimulus("basic", 1'b0, 3'b001, 1'b0, '0, {2'b00, (k % 5 == 0)});

    $display("[TB] cascade D0=4 D1=3");
    applyStimulus("casc_ld", 1'b0, 3'b000, 1'b1, packDiv(0, 3, 4), 3'b000);
    for (int k = 1; k <= 24; k++)
      applyStimulus("casc", 1'b0, 3'b011, 1'b0, '0, {1'b0, (k % 12 == 0), (k % 4 == 0)});

    $display("[TB] divisor of one");
    applyStimulus("d1_ld", 1'b0, 3'b001, 1'b1, packDiv(0, 0, 1), 3'b000);
    for (int k = 1; k <= 6; k++)
      applyStimulus("d1", 1'b0, 3'b001, 1'b0, '0, 3'b001);

    $display("[TB] divisor of zero then two");
    applyStimulus("d0_ld", 1'b0, 3'b001, 1'b1, packDiv(0, 0, 0), 3'b000);
    for (int k = 1; k <= 100; k++)
      applyStimulus("d0", 1'b0, 3'b001, 1'b0, '0, 3'b000);
    applyStimulus("d2_ld", 1'b0, 3'b001, 1'b1, packDiv(0, 0, 2), 3'b000);
    for (int k = 1; k <= 4; k++)
      applyStimulus("d2", 1'b0, 3'b001, 1'b0, '0, {2'b00, (k % 2 == 0)});

    $display("[TB] enable freeze D0=8");
    applyStimulus("frz_ld", 1'b0, 3'b001, 1'b1, packDiv(0, 0, 8), 3'b000);
    for (int k = 1; k <= 3; k++)
      applyStimulus("frz_run", 1'b0, 3'b001, 1'b0, '0, 3'b000);
    for (int k = 1; k <= 10; k++)
      applyStimulus("frz_hold", 1'b0, 3'b000, 1'b0, '0, 3'b000);
    for (int k = 1; k <= 6; k++)
      applyStimulus("frz_resume", 1'b0, 3'b001, 1'b0, '0, {2'b00, (k == 5)});

    $display("[TB] load on due wrap");
    applyStimulus("prio_ld0", 1'b0, 3'b001, 1'b1, packDiv(0, 0, 3), 3'b000);
    for (int k = 1; k <= 2; k++)
      applyStimulus("prio_pre", 1'b0, 3'b001, 1'b0, '0, 3'b000);
    applyStimulus("prio_ld1", 1'b0, 3'b001, 1'b1, packDiv(0, 0, 3), 3'b000);
    for (int k = 1; k <= 3; k++)
      applyStimulus("prio_post", 1'b0, 3'b001, 1'b0, '0, {2'b00, (k == 3)});

    $display("[TB] reset with load");
    applyStimulus("rst_ld", 1'b1, 3'b111, 1'b1, packDiv(7, 7, 7), 3'b000);
    applyStimulus("rst_after", 1'b0, 3'b000, 1'b0, '0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
